// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus slice: arbiter state encoding, bus owner
// type and the RTC register addresses written by the edit engine.
package rtc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_RD  = 2'd1;
  localparam logic [1:0] ST_GNT_WR  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } owner_e;

  // Time/date registers
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  // Timer registers
  localparam logic [7:0] ADDR_TSEC  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THOUR = 8'h43;

  function automatic logic is_edit_addr(input logic [7:0] addr);
    return ((addr >= ADDR_SEC) && (addr <= ADDR_YEAR)) ||
           ((addr >= ADDR_TSEC) && (addr <= ADDR_THOUR));
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh pacer: one-cycle refresh_tick every REFRESH_CYCLES clocks.
module rtc_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic clk,
  input  logic reset,
  output logic refresh_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign refresh_tick = (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Two-requester round-robin arbiter for the RTC register bus plus refresh pacing.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned CNT_W          = 24
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  output logic       refresh_tick,
  input  logic       rd_req,
  input  logic       rd_done,
  input  logic [7:0] rd_dir,
  input  logic       rd_lee,
  output logic       rd_gnt,
  input  logic       wr_req,
  input  logic       wr_done,
  input  logic [7:0] wr_dir,
  input  logic [7:0] wr_dato,
  input  logic       wr_escribe,
  output logic       wr_gnt,
  output logic [7:0] bus_dir,
  output logic [7:0] bus_dato,
  output logic       bus_escribe,
  output logic       bus_lee,
  output logic       timeout_err
);

  logic [1:0] state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       rd_req_q, wr_req_q;
  logic       in_grant;
  logic       tmo_hit;

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .CNT_W         (CNT_W)
  ) u_refresh (
    .clk         (clk),
    .reset       (reset),
    .refresh_tick(refresh_tick)
  );

  assign in_grant = (state_q == ST_GNT_RD) || (state_q == ST_GNT_WR);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = in_grant && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter idles at zero outside a grant, so grant entry always starts from 0.
  always_comb begin
    tmo_d = in_grant ? tmo_q + TMO_W'(1) : '0;
    err_d = err_q | tmo_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration looks at the registered requests, release at the live ones.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req_q && (!wr_req_q || (last_owner_q == OWN_WR))) begin
          state_d      = ST_GNT_RD;
          last_owner_d = OWN_RD;
        end else if (wr_req_q) begin
          state_d      = ST_GNT_WR;
          last_owner_d = OWN_WR;
        end
      end
      ST_GNT_RD: begin
        if (rd_done || !rd_req || tmo_hit) state_d = ST_RELEASE;
      end
      ST_GNT_WR: begin
        if (wr_done || !wr_req || tmo_hit) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_WR;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rd_req_q     <= rd_req;
      wr_req_q     <= wr_req;
    end
  end

  assign rd_gnt = (state_q == ST_GNT_RD);
  assign wr_gnt = (state_q == ST_GNT_WR);

  always_comb begin
    bus_dir     = '0;
    bus_dato    = '0;
    bus_escribe = 1'b0;
    bus_lee     = 1'b0;
    if (state_q == ST_GNT_RD) begin
      bus_dir = rd_dir;
      bus_lee = rd_lee;
    end else if (state_q == ST_GNT_WR) begin
      bus_dir     = wr_dir;
      bus_dato    = wr_dato;
      bus_escribe = wr_escribe;
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed self-checking bench for rtc_bus_arbiter (REFRESH_CYCLES=10).
module tb_rtc_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick;
  logic       rd_req, rd_done, rd_lee, rd_gnt;
  logic [7:0] rd_dir;
  logic       wr_req, wr_done, wr_escribe, wr_gnt;
  logic [7:0] wr_dir, wr_dato;
  logic [7:0] bus_dir, bus_dato;
  logic       bus_escribe, bus_lee, timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(
    .REFRESH_CYCLES(10),
    .CNT_W         (4)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .refresh_tick(refresh_tick),
    .rd_req      (rd_req),
    .rd_done     (rd_done),
    .rd_dir      (rd_dir),
    .rd_lee      (rd_lee),
    .rd_gnt      (rd_gnt),
    .wr_req      (wr_req),
    .wr_done     (wr_done),
    .wr_dir      (wr_dir),
    .wr_dato     (wr_dato),
    .wr_escribe  (wr_escribe),
    .wr_gnt      (wr_gnt),
    .bus_dir     (bus_dir),
    .bus_dato    (bus_dato),
    .bus_escribe (bus_escribe),
    .bus_lee     (bus_lee),
    .timeout_err (timeout_err)
  );

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    rd_req     = 1'b0;
    rd_done    = 1'b0;
    rd_dir     = 8'h00;
    rd_lee     = 1'b0;
    wr_req     = 1'b0;
    wr_done    = 1'b0;
    wr_dir     = 8'h00;
    wr_dato    = 8'h00;
    wr_escribe = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_total++;
    if ({refresh_tick, rd_gnt, wr_gnt, bus_dir, bus_dato, bus_escribe, bus_lee, timeout_err} !== '0) begin
      $display("FAIL reset_outputs: got tick=%b rg=%b wg=%b dir=%h dato=%h esc=%b lee=%b err=%b, want all 0",
               refresh_tick, rd_gnt, wr_gnt, bus_dir, bus_dato, bus_escribe, bus_lee, timeout_err);
    end else n_pass++;
  endtask

  task automatic test_refresh();
    int bad;
    apply_reset();
    bad = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (refresh_tick !== ((k % 10) == 9)) begin
        bad++;
        $display("FAIL refresh_tick cycle %0d: got %b want %b", k, refresh_tick, ((k % 10) == 9));
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_rd_single();
    apply_reset();
    rd_req = 1'b1;
    rd_dir = 8'h21;
    rd_lee = 1'b1;
    step(1);
    n_total++;
    if (rd_gnt !== 1'b0) $display("FAIL rd_gnt_after_edge0: got %b want 0", rd_gnt);
    else n_pass++;
    step(1);
    n_total++;
    if (rd_gnt !== 1'b1 || bus_dir !== 8'h21 || bus_lee !== 1'b1 || bus_dato !== 8'h00 || bus_escribe !== 1'b0)
      $display("FAIL rd_grant_bus: got gnt=%b dir=%h lee=%b dato=%h esc=%b want 1/21/1/00/0",
               rd_gnt, bus_dir, bus_lee, bus_dato, bus_escribe);
    else n_pass++;
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    rd_req  = 1'b0;
    n_total++;
    if (rd_gnt !== 1'b0 || bus_dir !== 8'h00 || bus_lee !== 1'b0)
      $display("FAIL rd_release_gap: got gnt=%b dir=%h lee=%b want 0/00/0", rd_gnt, bus_dir, bus_lee);
    else n_pass++;
    step(2);
    n_total++;
    if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0)
      $display("FAIL idle_after_release: got rg=%b wg=%b want 0/0", rd_gnt, wr_gnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    rd_req = 1'b1;
    wr_req = 1'b1;
    step(2);
    n_total++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0)
      $display("FAIL first_tie: got rg=%b wg=%b want 1/0", rd_gnt, wr_gnt);
    else n_pass++;
    rd_done = 1'b1;
    rd_req  = 1'b0;
    step(1);
    rd_done = 1'b0;
    n_total++;
    if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0)
      $display("FAIL tie_release_gap: got rg=%b wg=%b want 0/0", rd_gnt, wr_gnt);
    else n_pass++;
    step(2);
    n_total++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0)
      $display("FAIL pending_wr_served: got rg=%b wg=%b want 0/1", rd_gnt, wr_gnt);
    else n_pass++;
    rd_req  = 1'b1;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    step(2);
    n_total++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0)
      $display("FAIL second_tie: got rg=%b wg=%b want 1/0", rd_gnt, wr_gnt);
    else n_pass++;
  endtask

  task automatic test_wr_mux();
    apply_reset();
    wr_req     = 1'b1;
    wr_escribe = 1'b1;
    wr_dir     = 8'h22;
    wr_dato    = 8'h59;
    rd_lee     = 1'b1;
    rd_dir     = 8'h41;
    step(2);
    n_total++;
    if (wr_gnt !== 1'b1 || bus_escribe !== 1'b1 || bus_dir !== 8'h22 || bus_dato !== 8'h59 || bus_lee !== 1'b0)
      $display("FAIL wr_mux: got gnt=%b esc=%b dir=%h dato=%h lee=%b want 1/1/22/59/0",
               wr_gnt, bus_escribe, bus_dir, bus_dato, bus_lee);
    else n_pass++;
  endtask

  // Continues from the WR grant left by test_wr_mux.
  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (wr_gnt !== 1'b0 || bus_escribe !== 1'b0 || bus_dir !== 8'h00)
      $display("FAIL async_reset_drop: got wg=%b esc=%b dir=%h want 0/0/00", wr_gnt, bus_escribe, bus_dir);
    else n_pass++;
    rd_req = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    n_total++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0)
      $display("FAIL tie_after_reset: got rg=%b wg=%b want 1/0", rd_gnt, wr_gnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n_gnt;
    apply_reset();
    rd_req = 1'b1;
    step(1);
`ifdef ARB_TIMEOUT_EN
    n_gnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (rd_gnt === 1'b1) n_gnt++;
      else if (n_gnt > 0) break;
    end
    n_total++;
    if (n_gnt != 8) $display("FAIL timeout_grant_len: got %0d cycles want 8", n_gnt);
    else n_pass++;
    n_total++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err_set: got %b want 1", timeout_err);
    else n_pass++;
    rd_req = 1'b0;
    step(5);
    n_total++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", timeout_err);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_err_reset: got %b want 0", timeout_err);
    else n_pass++;
    reset = 1'b1;
`else
    n_gnt = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (rd_gnt === 1'b1) n_gnt++;
    end
    n_total++;
    if (n_gnt != 120) $display("FAIL grant_held: got %0d cycles want 120", n_gnt);
    else n_pass++;
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_err_tied: got %b want 0", timeout_err);
    else n_pass++;
`endif
  endtask

  initial begin
    reset      = 1'b0;
    rd_req     = 1'b0;
    rd_done    = 1'b0;
    rd_dir     = 8'h00;
    rd_lee     = 1'b0;
    wr_req     = 1'b0;
    wr_done    = 1'b0;
    wr_dir     = 8'h00;
    wr_dato    = 8'h00;
    wr_escribe = 1'b0;
    test_reset();
    test_refresh();
    test_rd_single();
    test_round_robin();
    test_wr_mux();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
